cpu_control_unit: RTL and testbench

Main sequencing FSM for the multicycle processor datapath. Decodes `OPCODE` and funct from the instruction register and drives every write enable, mux select and ALU operation so that fetch, decode, execute, memory and write-back occur in dedicated states. Supports `add`/`sub`/`and` R-type, `addi`, `lw`, `sw`, `beq`, `j`, `mult` and the overflow and invalid-opcode exceptions.

---
 rtl/cpu_control_unit_if.sv | 37 +++
 rtl/cpu_control_unit.sv | 178 +++++++++++++++++
 tb/tb_cpu_control_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: decoded-instruction inputs and every datapath strobe/select of the control unit.
// slave = control unit side, master = datapath side.
interface cpu_control_unit_if;
    logic [5:0] OPCODE;
    logic [5:0] FUNCT;
    logic       OVERFLOW;
    logic       ZERO;
    logic       mult_end;
    logic       PC_w;
    logic       EPC_w;
    logic       MEM_w;
    logic       IR_w;
    logic       AB_w;
    logic       RB_w;
    logic       ALUOut_w;
    logic       MEM_DATA_REG_w;
    logic       mult_control;
    logic [1:0] M_PC;
    logic [1:0] M_MEM;
    logic [1:0] M_EXC;
    logic [1:0] M_ALUSrcA;
    logic [1:0] M_ALUSrcB;
    logic [1:0] M_WREG;
    logic [3:0] ALUOp;
    logic [4:0] state;

    modport slave (
        input  OPCODE, FUNCT, OVERFLOW, ZERO, mult_end,
        output PC_w, EPC_w, MEM_w, IR_w, AB_w, RB_w, ALUOut_w, MEM_DATA_REG_w, mult_control,
        output M_PC, M_MEM, M_EXC, M_ALUSrcA, M_ALUSrcB, M_WREG, ALUOp, state
    );
    modport master (
        output OPCODE, FUNCT, OVERFLOW, ZERO, mult_end,
        input  PC_w, EPC_w, MEM_w, IR_w, AB_w, RB_w, ALUOut_w, MEM_DATA_REG_w, mult_control,
        input  M_PC, M_MEM, M_EXC, M_ALUSrcA, M_ALUSrcB, M_WREG, ALUOp, state
    );
endinterface

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multicycle sequencing FSM driving all datapath strobes and selects.
// Define CPU_CTRL_MULT_EN to enable the mult (funct 0x18) states; otherwise it traps as invalid.
module cpu_control_unit (
    input logic               clk,
    input logic               reset,
    cpu_control_unit_if.slave bus
);
    typedef enum logic [4:0] {
        RESET, FETCH0, FETCH1, FETCH2, DECODE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB,
        MEM_ADDR, LW_RD0, LW_RD1, LW_WB, SW_WR, BEQ, JUMP, MULT_START, MULT_WAIT,
        EXC_EPC0, EXC_EPC1, EXC_RD0, EXC_RD1, EXC_LOAD
    } state_t;

    localparam logic [3:0] ALU_A   = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;

    state_t     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic       is_r;
    logic [3:0] r_op;

    assign is_r = bus.OPCODE == 6'h00 &&
                  (bus.FUNCT == 6'h20 || bus.FUNCT == 6'h22 || bus.FUNCT == 6'h24);
    assign r_op = bus.FUNCT == 6'h22 ? ALU_SUB : bus.FUNCT == 6'h24 ? ALU_AND : ALU_ADD;
    assign bus.state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        code_d             = code_q;
        bus.PC_w           = 1'b0;
        bus.EPC_w          = 1'b0;
        bus.MEM_w          = 1'b0;
        bus.IR_w           = 1'b0;
        bus.AB_w           = 1'b0;
        bus.RB_w           = 1'b0;
        bus.ALUOut_w       = 1'b0;
        bus.MEM_DATA_REG_w = 1'b0;
        bus.mult_control   = 1'b0;
        bus.M_PC           = 2'd0;
        bus.M_MEM          = 2'd0;
        bus.M_EXC          = 2'd0;
        bus.M_ALUSrcA      = 2'd0;
        bus.M_ALUSrcB      = 2'd0;
        bus.M_WREG         = 2'd0;
        bus.ALUOp          = ALU_A;
        case (state_q)
            RESET: state_d = FETCH0;
            FETCH0: begin
                bus.M_ALUSrcB = 2'd1;
                bus.ALUOp     = ALU_ADD;
                bus.PC_w      = 1'b1;
                state_d       = FETCH1;
            end
            FETCH1: state_d = FETCH2;
            FETCH2: begin
                bus.IR_w = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                // ALUOut captures the branch target speculatively for BEQ
                bus.AB_w      = 1'b1;
                bus.M_ALUSrcB = 2'd3;
                bus.ALUOp     = ALU_ADD;
                bus.ALUOut_w  = 1'b1;
                if (is_r) state_d = R_EXEC;
`ifdef CPU_CTRL_MULT_EN
                else if (bus.OPCODE == 6'h00 && bus.FUNCT == 6'h18) state_d = MULT_START;
`endif
                else if (bus.OPCODE == 6'h08) state_d = ADDI_EXEC;
                else if (bus.OPCODE == 6'h23 || bus.OPCODE == 6'h2B) state_d = MEM_ADDR;
                else if (bus.OPCODE == 6'h04) state_d = BEQ;
                else if (bus.OPCODE == 6'h02) state_d = JUMP;
                else begin
                    state_d = EXC_EPC0;
                    code_d  = 2'd1;
                end
            end
            R_EXEC: begin
                bus.M_ALUSrcA = 2'd1;
                bus.ALUOp     = r_op;
                bus.ALUOut_w  = 1'b1;
                state_d       = bus.OVERFLOW && r_op != ALU_AND ? EXC_EPC0 : R_WB;
                code_d        = bus.OVERFLOW && r_op != ALU_AND ? 2'd0 : code_q;
            end
            R_WB: begin
                bus.RB_w   = 1'b1;
                bus.M_WREG = 2'd1;
                state_d    = FETCH0;
            end
            ADDI_EXEC: begin
                bus.M_ALUSrcA = 2'd1;
                bus.M_ALUSrcB = 2'd2;
                bus.ALUOp     = ALU_ADD;
                bus.ALUOut_w  = 1'b1;
                state_d       = bus.OVERFLOW ? EXC_EPC0 : ADDI_WB;
                code_d        = bus.OVERFLOW ? 2'd0 : code_q;
            end
            ADDI_WB, LW_WB: begin
                bus.RB_w = 1'b1;
                state_d  = FETCH0;
            end
            MEM_ADDR: begin
                bus.M_ALUSrcA = 2'd1;
                bus.M_ALUSrcB = 2'd2;
                bus.ALUOp     = ALU_ADD;
                bus.ALUOut_w  = 1'b1;
                state_d       = bus.OPCODE == 6'h23 ? LW_RD0 : SW_WR;
            end
            LW_RD0: begin
                bus.M_MEM = 2'd1;
                state_d   = LW_RD1;
            end
            LW_RD1: begin
                bus.M_MEM          = 2'd1;
                bus.MEM_DATA_REG_w = 1'b1;
                state_d            = LW_WB;
            end
            SW_WR: begin
                bus.M_MEM = 2'd1;
                bus.MEM_w = 1'b1;
                state_d   = FETCH0;
            end
            BEQ: begin
                bus.M_ALUSrcA = 2'd1;
                bus.ALUOp     = ALU_SUB;
                bus.M_PC      = 2'd1;
                bus.PC_w      = bus.ZERO;
                state_d       = FETCH0;
            end
            JUMP: begin
                bus.M_PC = 2'd2;
                bus.PC_w = 1'b1;
                state_d  = FETCH0;
            end
`ifdef CPU_CTRL_MULT_EN
            MULT_START: begin
                bus.mult_control = 1'b1;
                state_d          = MULT_WAIT;
            end
            MULT_WAIT: state_d = bus.mult_end ? FETCH0 : MULT_WAIT;
`endif
            EXC_EPC0: begin
                // PC was already advanced in FETCH0, so EPC gets PC-4
                bus.M_ALUSrcB = 2'd1;
                bus.ALUOp     = ALU_SUB;
                bus.ALUOut_w  = 1'b1;
                state_d       = EXC_EPC1;
            end
            EXC_EPC1: begin
                bus.EPC_w = 1'b1;
                state_d   = EXC_RD0;
            end
            EXC_RD0, EXC_RD1: begin
                bus.M_MEM = 2'd3;
                bus.M_EXC = code_q;
                state_d   = state_q == EXC_RD0 ? EXC_RD1 : EXC_LOAD;
            end
            EXC_LOAD: begin
                bus.M_ALUSrcA = 2'd2;
                bus.PC_w      = 1'b1;
                state_d       = FETCH0;
            end
            default: state_d = RESET;
        endcase
    end
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed instruction sequences with a per-cycle expected-output scoreboard.
module tb_cpu_control_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    cpu_control_unit_if bus();
    cpu_control_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    localparam int S_RESET = 0, S_F0 = 1, S_F1 = 2, S_F2 = 3, S_DEC = 4, S_REXEC = 5, S_RWB = 6;
    localparam int S_AEXEC = 7, S_AWB = 8, S_MADDR = 9, S_LRD0 = 10, S_LRD1 = 11, S_LWB = 12;
    localparam int S_SW = 13, S_BEQ = 14, S_J = 15, S_MS = 16, S_MW = 17;
    localparam int S_EPC0 = 18, S_EPC1 = 19, S_RD0 = 20, S_RD1 = 21, S_LOAD = 22;
    localparam int X_PC = 'h100, X_EPC = 'h80, X_MEM = 'h40, X_IR = 'h20, X_AB = 'h10;
    localparam int X_RB = 'h08, X_AO = 'h04, X_MDR = 'h02, X_MC = 'h01;
    localparam int ADD = 1, SUB = 2, AND = 3;
    // input vectors {reset, OVERFLOW, ZERO, mult_end}
    localparam logic [3:0] R0 = 4'b0000, R1 = 4'b1000, OV = 4'b1100, ZR = 4'b1010, ME = 4'b1001;

    typedef struct {
        string       tag;
        logic [3:0]  in;
        logic [29:0] v;
    } ent_t;
    ent_t q[$];
    int vectors = 0;
    int miscompares = 0;

    logic [29:0] obs;
    assign obs = {bus.PC_w, bus.EPC_w, bus.MEM_w, bus.IR_w, bus.AB_w, bus.RB_w, bus.ALUOut_w,
                  bus.MEM_DATA_REG_w, bus.mult_control, bus.M_PC, bus.M_MEM, bus.M_EXC,
                  bus.M_ALUSrcA, bus.M_ALUSrcB, bus.M_WREG, bus.ALUOp, bus.state};

    function automatic logic [29:0] e(int st, int s, int mpc, int mmem, int mexc, int sa, int sb,
                                      int wr, int op);
        return {9'(s), 2'(mpc), 2'(mmem), 2'(mexc), 2'(sa), 2'(sb), 2'(wr), 4'(op), 5'(st)};
    endfunction

    task automatic chk(string tag, logic [29:0] v);
        vectors++;
        assert (obs === v) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, v);
        end
    endtask

    task automatic p(string tag, logic [3:0] in, logic [29:0] v);
        ent_t x;
        x.tag = tag;
        x.in  = in;
        x.v   = v;
        q.push_back(x);
    endtask

    task automatic drain();
        ent_t x;
        while (q.size() > 0) begin
            x = q.pop_front();
            @(negedge clk);
            {reset, bus.OVERFLOW, bus.ZERO, bus.mult_end} = x.in;
            #2 chk(x.tag, x.v);
        end
    endtask

    task automatic instr(int op, int fn);
        bus.OPCODE = 6'(op);
        bus.FUNCT  = 6'(fn);
    endtask

    task automatic fetch(string t);
        p({t, "_f0"}, R1, e(S_F0, X_PC, 0, 0, 0, 0, 1, 0, ADD));
        p({t, "_f1"}, R1, e(S_F1, 0, 0, 0, 0, 0, 0, 0, 0));
        p({t, "_f2"}, R1, e(S_F2, X_IR, 0, 0, 0, 0, 0, 0, 0));
        p({t, "_dec"}, R1, e(S_DEC, X_AB | X_AO, 0, 0, 0, 0, 3, 0, ADD));
    endtask

    task automatic exc(string t, int c);
        p({t, "_epc0"}, R1, e(S_EPC0, X_AO, 0, 0, 0, 0, 1, 0, SUB));
        p({t, "_epc1"}, R1, e(S_EPC1, X_EPC, 0, 0, 0, 0, 0, 0, 0));
        p({t, "_rd0"}, R1, e(S_RD0, 0, 0, 3, c, 0, 0, 0, 0));
        p({t, "_rd1"}, R1, e(S_RD1, 0, 0, 3, c, 0, 0, 0, 0));
        p({t, "_load"}, R1, e(S_LOAD, X_PC, 0, 0, 0, 2, 0, 0, 0));
    endtask

    initial begin
        instr(0, 0);
        {bus.OVERFLOW, bus.ZERO, bus.mult_end} = 3'b000;
        p("reset", R0, e(S_RESET, 0, 0, 0, 0, 0, 0, 0, 0));
        p("reset_release", R1, e(S_RESET, 0, 0, 0, 0, 0, 0, 0, 0));
        drain();
        instr(0, 'h20);
        fetch("add");
        p("add_exec", R1, e(S_REXEC, X_AO, 0, 0, 0, 1, 0, 0, ADD));
        p("add_wb", R1, e(S_RWB, X_RB, 0, 0, 0, 0, 0, 1, 0));
        drain();
        instr(0, 'h22);
        fetch("sub_ovf");
        p("sub_exec", OV, e(S_REXEC, X_AO, 0, 0, 0, 1, 0, 0, SUB));
        exc("sub_ovf", 0);
        drain();
        instr(0, 'h24);
        fetch("and");
        p("and_exec", OV, e(S_REXEC, X_AO, 0, 0, 0, 1, 0, 0, AND));
        p("and_wb", R1, e(S_RWB, X_RB, 0, 0, 0, 0, 0, 1, 0));
        drain();
        instr('h08, 0);
        fetch("addi");
        p("addi_exec", R1, e(S_AEXEC, X_AO, 0, 0, 0, 1, 2, 0, ADD));
        p("addi_wb", R1, e(S_AWB, X_RB, 0, 0, 0, 0, 0, 0, 0));
        drain();
        fetch("addi_ovf");
        p("addi_ovf_exec", OV, e(S_AEXEC, X_AO, 0, 0, 0, 1, 2, 0, ADD));
        exc("addi_ovf", 0);
        drain();
        instr('h23, 0);
        fetch("lw");
        p("lw_addr", ME, e(S_MADDR, X_AO, 0, 0, 0, 1, 2, 0, ADD));
        p("lw_rd0", ME, e(S_LRD0, 0, 0, 1, 0, 0, 0, 0, 0));
        p("lw_rd1", ME, e(S_LRD1, X_MDR, 0, 1, 0, 0, 0, 0, 0));
        p("lw_wb", ME, e(S_LWB, X_RB, 0, 0, 0, 0, 0, 0, 0));
        drain();
        instr('h2B, 0);
        fetch("sw");
        p("sw_addr", R1, e(S_MADDR, X_AO, 0, 0, 0, 1, 2, 0, ADD));
        p("sw_wr", R1, e(S_SW, X_MEM, 0, 1, 0, 0, 0, 0, 0));
        drain();
        instr('h04, 0);
        fetch("beq_t");
        p("beq_taken", ZR, e(S_BEQ, X_PC, 1, 0, 0, 1, 0, 0, SUB));
        drain();
        bus.ZERO = 1'b0;
        #1 chk("beq_mealy", e(S_BEQ, 0, 1, 0, 0, 1, 0, 0, SUB));
        fetch("beq_nt");
        p("beq_not_taken", R1, e(S_BEQ, 0, 1, 0, 0, 1, 0, 0, SUB));
        drain();
        instr('h02, 0);
        fetch("j");
        p("jump", R1, e(S_J, X_PC, 2, 0, 0, 0, 0, 0, 0));
        drain();
        instr('h3F, 0);
        fetch("inv");
        exc("inv", 1);
        drain();
        instr(0, 'h18);
        fetch("mult");
`ifdef CPU_CTRL_MULT_EN
        p("mult_start", R1, e(S_MS, X_MC, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 33; i++)
            p("mult_wait", i == 32 ? ME : R1, e(S_MW, 0, 0, 0, 0, 0, 0, 0, 0));
`else
        exc("mult_off", 1);
`endif
        drain();
        instr('h23, 0);
        fetch("lw_rst");
        p("lw_rst_addr", R1, e(S_MADDR, X_AO, 0, 0, 0, 1, 2, 0, ADD));
        p("lw_rst_rd0", R1, e(S_LRD0, 0, 0, 1, 0, 0, 0, 0, 0));
        drain();
        #1 reset = 1'b0;
        #1 chk("rst_async", e(S_RESET, 0, 0, 0, 0, 0, 0, 0, 0));
        p("rst_hold", R0, e(S_RESET, 0, 0, 0, 0, 0, 0, 0, 0));
        p("rst_release", R1, e(S_RESET, 0, 0, 0, 0, 0, 0, 0, 0));
        fetch("post_rst");
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
